// File: rtl/bg_fill_engine.sv
// Frame-fill engine: walks an H_RES x V_RES grid and emits one (x, y, colour) plot per
// enabled cycle, colour taken from a 1-bit background RAM or a solid colour latched at start.
module bg_fill_engine #(
   parameter int unsigned H_RES     = 160,
   parameter int unsigned V_RES     = 120,
   parameter int unsigned X_W       = 8,
   parameter int unsigned Y_W       = 8,
   parameter int unsigned ADDR_W    = 15,
   parameter int unsigned COLOR_W   = 12,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned LOOP      = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               enable,
   input  logic               fill_mode,
   input  logic [COLOR_W-1:0] fill_color,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_q,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic [COLOR_W-1:0] color,
   output logic               plot,
   output logic               busy,
   output logic               done
);

   localparam logic [X_W-1:0]    X_LAST  = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(V_RES - 1);
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam bit                LOOP_EN = (LOOP != 0);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

   state_t               state_q, state_d;
   logic [X_W-1:0]       xc_q, xc_d;
   logic [Y_W-1:0]       yc_q, yc_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 mode_q, mode_d;
   logic [COLOR_W-1:0]   fcol_q, fcol_d;
   logic                 stop_q, stop_d;

   logic                 s1_valid_q, s1_last_q;
   logic [X_W-1:0]       s1_x_q;
   logic [Y_W-1:0]       s1_y_q;

   logic [X_W-1:0]       x_q;
   logic [Y_W-1:0]       y_q;
   logic [COLOR_W-1:0]   color_q;
   logic                 plot_q, done_q;

   logic                 issue, at_xend, at_last;

   assign issue   = (state_q == S_SCAN) && enable;
   assign at_xend = (xc_q == X_LAST);
   assign at_last = at_xend && (yc_q == Y_LAST);

   always_comb begin
      state_d = state_q;
      xc_d    = xc_q;
      yc_d    = yc_q;
      addr_d  = addr_q;
      mode_d  = mode_q;
      fcol_d  = fcol_q;
      stop_d  = stop_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = fill_mode;
               fcol_d  = fill_color;
               xc_d    = '0;
               yc_d    = '0;
               addr_d  = BASE;
               stop_d  = 1'b0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (stop) stop_d = 1'b1;
            if (enable) begin
               // Address runs alongside the counters so it never needs y*H_RES.
               if (at_last) begin
                  xc_d   = '0;
                  yc_d   = '0;
                  addr_d = BASE;
                  if (!LOOP_EN || stop_q || stop) begin
                     state_d = S_DRAIN;
                     stop_d  = 1'b0;
                  end
               end else if (at_xend) begin
                  xc_d   = '0;
                  yc_d   = yc_q + Y_W'(1);
                  addr_d = addr_q + ADDR_W'(1);
               end else begin
                  xc_d   = xc_q + X_W'(1);
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (done_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         xc_q       <= '0;
         yc_q       <= '0;
         addr_q     <= BASE;
         mode_q     <= 1'b0;
         fcol_q     <= '0;
         stop_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         color_q    <= '0;
         plot_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         xc_q       <= xc_d;
         yc_q       <= yc_d;
         addr_q     <= addr_d;
         mode_q     <= mode_d;
         fcol_q     <= fcol_d;
         stop_q     <= stop_d;
         s1_valid_q <= issue;
         if (issue) begin
            s1_x_q    <= xc_q;
            s1_y_q    <= yc_q;
            s1_last_q <= at_last;
         end
         // mem_q belongs to the stage-1 pixel: its address was presented last cycle.
         plot_q <= s1_valid_q;
         done_q <= s1_valid_q & s1_last_q;
         if (s1_valid_q) begin
            x_q     <= s1_x_q;
            y_q     <= s1_y_q;
            color_q <= mode_q ? fcol_q : {COLOR_W{mem_q}};
         end
      end
   end

   assign mem_addr = addr_q;
   assign x        = x_q;
   assign y        = y_q;
   assign color    = color_q;
   assign plot     = plot_q;
   assign done     = done_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bg_fill_engine.sv
// Directed bench for bg_fill_engine: small 4x3 grids (one-shot and looping) and the
// default 160x120 grid, each fed by a model RAM holding 1 at even addresses.
module tb_bg_fill_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic reset;

   logic        a_start, a_stop, a_en, a_mode, a_q, a_plot, a_busy, a_done;
   logic [11:0] a_fcol, a_col;
   logic [14:0] a_addr;
   logic [7:0]  a_x, a_y;

   logic        b_start, b_stop, b_en, b_mode, b_q, b_plot, b_busy, b_done;
   logic [11:0] b_fcol, b_col;
   logic [14:0] b_addr;
   logic [7:0]  b_x, b_y;

   logic        c_start, c_stop, c_en, c_mode, c_q, c_plot, c_busy, c_done;
   logic [11:0] c_fcol, c_col;
   logic [14:0] c_addr;
   logic [7:0]  c_x, c_y;

   bg_fill_engine #(.H_RES(4), .V_RES(3), .X_W(8), .Y_W(8), .ADDR_W(15), .COLOR_W(12),
                    .BASE_ADDR(0), .LOOP(0)) u_a (
      .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .enable(a_en),
      .fill_mode(a_mode), .fill_color(a_fcol), .mem_addr(a_addr), .mem_q(a_q),
      .x(a_x), .y(a_y), .color(a_col), .plot(a_plot), .busy(a_busy), .done(a_done));

   bg_fill_engine #(.H_RES(4), .V_RES(3), .X_W(8), .Y_W(8), .ADDR_W(15), .COLOR_W(12),
                    .BASE_ADDR(100), .LOOP(1)) u_b (
      .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .enable(b_en),
      .fill_mode(b_mode), .fill_color(b_fcol), .mem_addr(b_addr), .mem_q(b_q),
      .x(b_x), .y(b_y), .color(b_col), .plot(b_plot), .busy(b_busy), .done(b_done));

   bg_fill_engine u_c (
      .clk(clk), .reset(reset), .start(c_start), .stop(c_stop), .enable(c_en),
      .fill_mode(c_mode), .fill_color(c_fcol), .mem_addr(c_addr), .mem_q(c_q),
      .x(c_x), .y(c_y), .color(c_col), .plot(c_plot), .busy(c_busy), .done(c_done));

   // Background RAMs: 1-cycle synchronous read, 1 at even addresses.
   always @(posedge clk) begin
      a_q <= ~a_addr[0];
      b_q <= ~b_addr[0];
      c_q <= ~c_addr[0];
   end

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (a_plot !== 1'b0) begin failures++; $display("FAIL reset_plot got %b exp 0", a_plot); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", a_busy); end
      checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", a_done); end
      checks++; if (a_addr !== 15'd0) begin failures++; $display("FAIL reset_addr_a got %0d exp 0", a_addr); end
      checks++; if (b_addr !== 15'd100) begin failures++; $display("FAIL reset_addr_b got %0d exp 100", b_addr); end
      checks++; if (a_x !== 8'd0 || a_y !== 8'd0 || a_col !== 12'd0)
         begin failures++; $display("FAIL reset_xyc got %0d,%0d,%h exp 0,0,000", a_x, a_y, a_col); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_raster;
      logic e_plot, e_busy;
      logic [11:0] ecol;
      int k;
      a_mode = 1'b0; a_en = 1'b1; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL raster_busy_rise got %b exp 1", a_busy); end
      checks++; if (a_plot !== 1'b0) begin failures++; $display("FAIL raster_noplot0 got %b exp 0", a_plot); end
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         k      = c - 2;
         e_plot = (k >= 0 && k < 12);
         e_busy = (c <= 13);
         checks++; if (a_plot !== e_plot) begin failures++; $display("FAIL raster_plot c=%0d got %b exp %b", c, a_plot, e_plot); end
         checks++; if (a_busy !== e_busy) begin failures++; $display("FAIL raster_busy c=%0d got %b exp %b", c, a_busy, e_busy); end
         checks++; if (a_done !== (k == 11)) begin failures++; $display("FAIL raster_done c=%0d got %b exp %b", c, a_done, k == 11); end
         if (e_plot) begin
            ecol = (k % 2 == 0) ? 12'hFFF : 12'h000;
            checks++; if (a_x !== 8'(k % 4) || a_y !== 8'(k / 4))
               begin failures++; $display("FAIL raster_xy k=%0d got %0d,%0d exp %0d,%0d", k, a_x, a_y, k % 4, k / 4); end
            checks++; if (a_col !== ecol) begin failures++; $display("FAIL raster_color k=%0d got %h exp %h", k, a_col, ecol); end
         end
      end
   endtask

   task automatic test_enable_throttle;
      logic [31:0] pat = 32'b1011_0010_0111_0100_1100_1010_0011_0101;
      logic [11:0] ecol;
      int p = 0;
      int iss = 0;
      a_mode = 1'b0; a_en = 1'b0; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (a_plot) begin
            ecol = (p % 2 == 0) ? 12'hFFF : 12'h000;
            checks++; if (p >= 12) begin failures++; $display("FAIL throttle_extra_plot got %0d exp 12", p + 1); end
            checks++; if (a_x !== 8'(p % 4) || a_y !== 8'(p / 4))
               begin failures++; $display("FAIL throttle_xy p=%0d got %0d,%0d exp %0d,%0d", p, a_x, a_y, p % 4, p / 4); end
            checks++; if (a_col !== ecol) begin failures++; $display("FAIL throttle_color p=%0d got %h exp %h", p, a_col, ecol); end
            checks++; if (a_done !== (p == 11)) begin failures++; $display("FAIL throttle_done p=%0d got %b exp %b", p, a_done, p == 11); end
            p++;
         end else begin
            checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL throttle_done_noplot got %b exp 0", a_done); end
         end
         a_en = pat[c % 32];
         if (a_en && iss < 12) begin
            checks++; if (a_addr !== 15'(iss)) begin failures++; $display("FAIL throttle_addr i=%0d got %0d exp %0d", iss, a_addr, iss); end
            iss++;
         end
         @(negedge clk);
      end
      a_en = 1'b1;
      checks++; if (p != 12) begin failures++; $display("FAIL throttle_count got %0d exp 12", p); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL throttle_busy_end got %b exp 0", a_busy); end
   endtask

   task automatic test_solid;
      int p = 0;
      int dn = 0;
      a_mode = 1'b1; a_fcol = 12'hA5C; a_en = 1'b1; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0; a_fcol = 12'h123; a_mode = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (a_plot) begin
            checks++; if (a_col !== 12'hA5C) begin failures++; $display("FAIL solid_color p=%0d got %h exp a5c", p, a_col); end
            checks++; if (a_x !== 8'(p % 4) || a_y !== 8'(p / 4))
               begin failures++; $display("FAIL solid_xy p=%0d got %0d,%0d exp %0d,%0d", p, a_x, a_y, p % 4, p / 4); end
            p++;
         end
         if (a_done) dn++;
         a_start = (c == 3 || c == 8 || c == 13);
         @(negedge clk);
      end
      a_start = 1'b0;
      checks++; if (p != 12) begin failures++; $display("FAIL solid_count got %0d exp 12", p); end
      checks++; if (dn != 1) begin failures++; $display("FAIL solid_dones got %0d exp 1", dn); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL solid_busy_end got %b exp 0", a_busy); end
   endtask

   task automatic test_loop;
      logic [11:0] ecol;
      int p = 0;
      int iss = 0;
      int dn = 0;
      int k;
      b_mode = 1'b0; b_en = 1'b1; b_stop = 1'b0; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      for (int c = 0; c < 70; c++) begin
         b_stop = 1'b0;
         if (b_plot) begin
            k    = p % 12;
            ecol = (k % 2 == 0) ? 12'hFFF : 12'h000;
            checks++; if (b_x !== 8'(k % 4) || b_y !== 8'(k / 4))
               begin failures++; $display("FAIL loop_xy p=%0d got %0d,%0d exp %0d,%0d", p, b_x, b_y, k % 4, k / 4); end
            checks++; if (b_col !== ecol) begin failures++; $display("FAIL loop_color p=%0d got %h exp %h", p, b_col, ecol); end
            checks++; if (b_done !== (k == 11)) begin failures++; $display("FAIL loop_done p=%0d got %b exp %b", p, b_done, k == 11); end
            if (b_done) dn++;
            if (p == 16) b_stop = 1'b1;
            p++;
         end
         if (iss < 24) begin
            checks++; if (b_addr !== 15'(100 + iss % 12))
               begin failures++; $display("FAIL loop_addr i=%0d got %0d exp %0d", iss, b_addr, 100 + iss % 12); end
            iss++;
         end
         @(negedge clk);
      end
      b_stop = 1'b0;
      checks++; if (p != 24) begin failures++; $display("FAIL loop_count got %0d exp 24", p); end
      checks++; if (dn != 2) begin failures++; $display("FAIL loop_dones got %0d exp 2", dn); end
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL loop_busy_end got %b exp 0", b_busy); end
   endtask

   task automatic test_reset_mid;
      logic [11:0] ecol;
      int p = 0;
      int dn = 0;
      a_mode = 1'b0; a_en = 1'b1; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (a_plot) p++;
         if (p == 7) break;
         @(negedge clk);
      end
      checks++; if (p != 7) begin failures++; $display("FAIL rstmid_reach7 got %0d exp 7", p); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (a_plot !== 1'b0) begin failures++; $display("FAIL rstmid_plot got %b exp 0", a_plot); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b exp 0", a_busy); end
      checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got %b exp 0", a_done); end
      checks++; if (a_addr !== 15'd0) begin failures++; $display("FAIL rstmid_addr got %0d exp 0", a_addr); end
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      p = 0;
      for (int c = 0; c < 25; c++) begin
         if (a_plot) begin
            ecol = (p % 2 == 0) ? 12'hFFF : 12'h000;
            checks++; if (a_x !== 8'(p % 4) || a_y !== 8'(p / 4))
               begin failures++; $display("FAIL rstmid_xy p=%0d got %0d,%0d exp %0d,%0d", p, a_x, a_y, p % 4, p / 4); end
            checks++; if (a_col !== ecol) begin failures++; $display("FAIL rstmid_color p=%0d got %h exp %h", p, a_col, ecol); end
            p++;
         end
         if (a_done) dn++;
         @(negedge clk);
      end
      checks++; if (p != 12) begin failures++; $display("FAIL rstmid_count got %0d exp 12", p); end
      checks++; if (dn != 1) begin failures++; $display("FAIL rstmid_dones got %0d exp 1", dn); end
   endtask

   task automatic test_default;
      logic [11:0] ecol;
      int p = 0;
      int dn = 0;
      c_mode = 1'b0; c_en = 1'b1; c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      for (int c = 0; c < 19220; c++) begin
         checks++; if (c_addr > 15'd19199) begin failures++; $display("FAIL dflt_addr_range got %0d exp <=19199", c_addr); end
         if (c_plot) begin
            ecol = (p % 2 == 0) ? 12'hFFF : 12'h000;
            checks++; if (c_x !== 8'(p % 160) || c_y !== 8'(p / 160))
               begin failures++; $display("FAIL dflt_xy p=%0d got %0d,%0d exp %0d,%0d", p, c_x, c_y, p % 160, p / 160); end
            checks++; if (c_col !== ecol) begin failures++; $display("FAIL dflt_color p=%0d got %h exp %h", p, c_col, ecol); end
            checks++; if (c_done !== (p == 19199)) begin failures++; $display("FAIL dflt_done p=%0d got %b exp %b", p, c_done, p == 19199); end
            p++;
         end
         if (c_done) dn++;
         @(negedge clk);
      end
      checks++; if (p != 19200) begin failures++; $display("FAIL dflt_count got %0d exp 19200", p); end
      checks++; if (dn != 1) begin failures++; $display("FAIL dflt_dones got %0d exp 1", dn); end
      checks++; if (c_x !== 8'd159 || c_y !== 8'd119)
         begin failures++; $display("FAIL dflt_last_xy got %0d,%0d exp 159,119", c_x, c_y); end
      checks++; if (c_busy !== 1'b0) begin failures++; $display("FAIL dflt_busy_end got %b exp 0", c_busy); end
   endtask

   initial begin
      reset = 1'b1;
      a_start = 1'b0; a_stop = 1'b0; a_en = 1'b0; a_mode = 1'b0; a_fcol = 12'h000;
      b_start = 1'b0; b_stop = 1'b0; b_en = 1'b0; b_mode = 1'b0; b_fcol = 12'h000;
      c_start = 1'b0; c_stop = 1'b0; c_en = 1'b0; c_mode = 1'b0; c_fcol = 12'h000;
      test_reset;
      test_raster;
      repeat (2) @(negedge clk);
      test_enable_throttle;
      repeat (2) @(negedge clk);
      test_solid;
      repeat (2) @(negedge clk);
      test_loop;
      repeat (2) @(negedge clk);
      test_reset_mid;
      repeat (2) @(negedge clk);
      test_default;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bg_fill_engine.md
Name: bg_fill_engine

Overview:
- Parametrised frame-fill engine that walks an H_RES x V_RES pixel grid and emits one (x, y, colour) plot per enabled cycle to the VGA adapter's pixel write port.
- Colour comes either from a 1-bit background RAM (1-cycle synchronous read), replicated across the colour word, or from a solid colour latched at start.
- Adds what the previous clear block lacked: start/busy/done handshake, pipeline-aligned address and coordinates, incremental addressing with no multiplier, selectable fill mode, and optional continuous looping with a clean end-of-frame stop.

Parameters:
- H_RES, 160, pixels per line; must be >= 2.
- V_RES, 120, lines per frame; must be >= 2.
- X_W, 8, width of x outputs; must satisfy 2^X_W >= H_RES.
- Y_W, 8, width of y outputs; must satisfy 2^Y_W >= V_RES.
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= BASE_ADDR + H_RES*V_RES.
- COLOR_W, 12, width of colour output.
- BASE_ADDR, 0, RAM address of pixel (0,0).
- LOOP, 0, 1 = restart at (0,0) after each frame until stop is seen.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; honoured only in IDLE.
- stop  in  1  LOOP=1 only: finish the current frame, then go idle. Sticky until honoured.
- enable  in  1  throttle; a pixel is issued only in cycles with enable=1.
- fill_mode  in  1  0 = RAM colour, 1 = solid fill_color; latched on an accepted start.
- fill_color  in  COLOR_W  solid colour; latched on an accepted start.
- mem_addr  out  ADDR_W  background RAM read address (registered).
- mem_q  in  1  RAM read data, valid 1 cycle after mem_addr.
- x  out  X_W  plot x coordinate.
- y  out  Y_W  plot y coordinate.
- color  out  COLOR_W  plot colour.
- plot  out  1  x/y/color valid this cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse, coincident with the plot of the last pixel (H_RES-1, V_RES-1).

Behaviour:
- Reset: state IDLE; x, y, color, plot, busy, done = 0; mem_addr = BASE_ADDR; internal counters at 0; pipeline valids cleared; stop latch cleared. Reset mid-frame abandons the frame with no done pulse.
- States:
  - IDLE: start=1 latches fill_mode/fill_color, clears counters, sets mem_addr = BASE_ADDR, goes to SCAN.
  - SCAN: each cycle with enable=1 issues the pixel at (xc, yc, mem_addr).
  - DRAIN: waits for the last pixel to reach the output; the done cycle returns to IDLE.
  - start is ignored in SCAN and DRAIN.
- Issue, SCAN with enable=1:
  - stage-1 regs <= {valid=1, xc, yc, last=(xc==H_RES-1 && yc==V_RES-1)}.
  - Advance: xc+1; at xc==H_RES-1, xc <= 0 and yc+1.
  - mem_addr+1; at the last pixel, mem_addr <= BASE_ADDR.
  - No multiply; the address is always BASE_ADDR + yc*H_RES + xc.
- Stall, enable=0: counters and mem_addr hold; stage-1 valid <= 0. Enable may toggle on any cycle.
- Output stage, registered from stage 1:
  - plot <= s1.valid; x/y <= s1 coordinates.
  - color <= fill_mode_l ? fill_color_l : {COLOR_W{mem_q}}.
  - done <= s1.valid & s1.last.
- Latency: the pixel issued in cycle N plots in cycle N+2. Plots appear in raster order with no gaps beyond enable gaps, and no duplicates.
- The downstream consumer always accepts; enable is the only throttle.
- Frame end:
  - LOOP=0: issuing the last pixel -> DRAIN.
  - LOOP=1: counters wrap and SCAN continues; done pulses each frame. If the stop latch is set when the last pixel issues -> DRAIN.
  - A stop asserted mid-frame never truncates the frame.
- busy stays high through DRAIN and falls the cycle after done.
- Outputs hold their last value when plot=0, but consumers must ignore them.
- mem_addr is driven during solid fill too; the RAM is never written.

Test Plan:
- H_RES=4, V_RES=3, LOOP=0, enable=1, fill_mode=0, RAM holds 1 at even addresses -> 12 plots on consecutive cycles. First plot 2 cycles after the SCAN entry cycle. Raster (0,0)..(3,2). color = 0xFFF at even index, else 0x000. done coincident with (3,2); busy falls next cycle.
- Same config, enable toggled by a pseudo-random 50% pattern -> exactly 12 plots, raster order, each colour matching its own address. mem_addr = y*4+x for each issued pixel.
- fill_mode=1, fill_color=0xA5C latched, then fill_color changed mid-frame -> all 12 plots carry 0xA5C. start pulses during busy are ignored: no restart, no extra done.
- LOOP=1, BASE_ADDR=100 -> mem_addr sequence 100..111,100..; done every 12 plots. stop pulsed at the 5th plot of frame 2 -> frame 2 completes, done, busy falls, no plot of frame 3.
- reset asserted after the 7th plot -> next cycle plot=0, busy=0, done=0, mem_addr=BASE_ADDR. A new start gives a full frame from (0,0).
- Default params (160x120) -> 19200 plots; last plot (159,119); mem_addr never exceeds 19199; x/y never exceed 159/119.
